// File: rtl/uu_acmac_tx_mem_reader.sv
// uu_acmac_tx_mem_reader
// Reads a frame out of the ACMAC TX frame buffer (8-bit wide, 1-cycle synchronous
// read) and streams it to the PHY-side byte interface under valid/ready flow control.
// A small prefetch FIFO covers the read latency. The output register is loaded
// straight from mem_rdata when the FIFO is empty, so a frame runs at one byte per cycle.
//
// Optional feature: define ACMAC_TX_FCS_EN to append a 4-byte CRC-32 (reflected
// 04C11DB7, init FFFFFFFF, final invert) after the payload, LS byte first.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start/base_addr/frame_len  frame command (sampled only while idle)
//   abort                    cancel the frame in progress
//   mem_en/mem_wen/mem_addr  buffer read port (mem_wen tied low)
//   mem_rdata                buffer read data, valid the cycle after mem_en
//   out_valid/out_ready      byte stream handshake
//   out_data/out_last        byte and end-of-frame marker
//   busy, done, aborted      frame status (done/aborted are 1-cycle pulses)
module uu_acmac_tx_mem_reader #(
  parameter int ADDR_W     = 8,
  parameter int MEM_DEPTH  = 208,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              abort,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  // state  | meaning
  // IDLE   | waiting for start
  // READ   | issuing buffer reads
  // DRAIN  | all reads issued, emptying FIFO / output register
  // FCS    | sending the 4 CRC bytes (ACMAC_TX_FCS_EN only)
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
`ifdef ACMAC_TX_FCS_EN
  localparam logic [1:0] S_FCS   = 2'd3;
`endif

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]       DEPTH_C   = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MEM_DEPTH);

  logic [1:0]       state;
  logic [LEN_W-1:0] rd_left;
  logic [LEN_W-1:0] emit_left;
  logic             inflight;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    fcnt;

  logic [CW:0]      occ;
  logic [LEN_W-1:0] len_eff;
  logic             hs, slot_free, fifo_pop, fifo_push, bypass, pay_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef ACMAC_TX_FCS_EN
  logic [31:0] crc;
  logic [31:0] crc_fin;
  logic [23:0] fcs_sr;
  logic [1:0]  fcs_idx;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign crc_fin  = ~crc_byte(crc, out_data);
  assign out_last = out_valid && (state == S_FCS) && (fcs_idx == 2'd3);
`else
  assign out_last = out_valid && (state == S_DRAIN) && (emit_left == LEN_W'(1));
`endif

  assign mem_wen = 1'b0;
  assign busy    = (state != S_IDLE);

  always_comb begin
    len_eff   = (int'(frame_len) > MEM_DEPTH) ? LEN_MAX : frame_len;
    occ       = {1'b0, fcnt} + (CW+1)'(inflight);
    mem_en    = (state == S_READ) && (occ < DEPTH_C);
    hs        = out_valid && out_ready;
    slot_free = !out_valid || out_ready;
    fifo_pop  = slot_free && (fcnt != '0);
    // Skip the FIFO when it is empty and the output register can take the byte.
    bypass    = slot_free && (fcnt == '0) && inflight;
    fifo_push = inflight && !bypass;
    pay_last  = hs && (state == S_DRAIN) && (emit_left == LEN_W'(1));
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wptr] <= mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_left   <= '0;
      emit_left <= '0;
      inflight  <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      fcnt      <= '0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
`ifdef ACMAC_TX_FCS_EN
      crc       <= '1;
      fcs_sr    <= '0;
      fcs_idx   <= '0;
`endif
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (abort && state != S_IDLE) begin
        // Flush everything, including the read returning this cycle.
        state     <= S_IDLE;
        inflight  <= 1'b0;
        wptr      <= '0;
        rptr      <= '0;
        fcnt      <= '0;
        out_valid <= 1'b0;
        aborted   <= 1'b1;
      end else begin
        inflight <= mem_en;
        if (mem_en) begin
          mem_addr <= (mem_addr == ADDR_LAST) ? '0 : mem_addr + ADDR_W'(1);
          rd_left  <= rd_left - LEN_W'(1);
          if (rd_left == LEN_W'(1)) state <= S_DRAIN;
        end
        if (fifo_push) wptr <= ptr_inc(wptr);
        if (fifo_pop)  rptr <= ptr_inc(rptr);
        fcnt <= fcnt + CW'(fifo_push) - CW'(fifo_pop);
        if (slot_free) begin
          if (fifo_pop) begin
            out_valid <= 1'b1;
            out_data  <= fifo_mem[rptr];
          end else if (bypass) begin
            out_valid <= 1'b1;
            out_data  <= mem_rdata;
          end else begin
            out_valid <= 1'b0;
          end
        end
        if (hs && (state == S_READ || state == S_DRAIN)) begin
          emit_left <= emit_left - LEN_W'(1);
`ifdef ACMAC_TX_FCS_EN
          crc <= crc_byte(crc, out_data);
`endif
        end
        if (pay_last) begin
`ifdef ACMAC_TX_FCS_EN
          // First FCS byte goes out right behind the last payload byte.
          state     <= S_FCS;
          out_valid <= 1'b1;
          out_data  <= crc_fin[7:0];
          fcs_sr    <= crc_fin[31:8];
          fcs_idx   <= 2'd0;
`else
          state <= S_IDLE;
          done  <= 1'b1;
`endif
        end
`ifdef ACMAC_TX_FCS_EN
        if (state == S_FCS && hs) begin
          if (fcs_idx == 2'd3) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end else begin
            out_valid <= 1'b1;
            out_data  <= fcs_sr[7:0];
            fcs_sr    <= {8'h00, fcs_sr[23:8]};
            fcs_idx   <= fcs_idx + 2'd1;
          end
        end
`endif
        if (state == S_IDLE && start) begin
          if (len_eff == '0) begin
            done <= 1'b1;
          end else begin
            state     <= S_READ;
            mem_addr  <= base_addr;
            rd_left   <= len_eff;
            emit_left <= len_eff;
`ifdef ACMAC_TX_FCS_EN
            crc       <= '1;
`endif
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_uu_acmac_tx_mem_reader.sv
module tb_uu_acmac_tx_mem_reader;
  localparam int DEPTH = 208;
  localparam int FDEP  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [7:0] frame_len = '0;
  logic       abort = 1'b0;
  logic       mem_en, mem_wen;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last, busy, done, aborted;

  uu_acmac_tx_mem_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .frame_len(frame_len),
    .abort(abort), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_arr [0:DEPTH-1];
  always @(posedge clk) if (mem_en) mem_rdata <= mem_arr[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int rmode = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  int checks = 0, errors = 0;
  int n_rd, n_acc, n_done, n_ab, done_cyc, last_hs_cyc, first_v_cyc;
  int occ_bad, stab_bad, busy_bad, wen_bad, addr_bad;
  int s_cyc = -10, exp_len_now = 0;
  bit busy_chk = 0;
  byte unsigned got_q[$];
  bit last_q[$];
  logic prev_v = 0, prev_r = 0;
  logic [7:0] prev_d = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_rd = 0; n_acc = 0; n_done = 0; n_ab = 0; done_cyc = -1; last_hs_cyc = -1; first_v_cyc = -1;
    occ_bad = 0; stab_bad = 0; busy_bad = 0; wen_bad = 0; addr_bad = 0;
    got_q.delete(); last_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wen) wen_bad++;
      if (mem_en && mem_addr >= DEPTH) addr_bad++;
      // issued-but-unaccepted bytes minus the output register = FIFO + in flight
      if (n_rd + int'(mem_en) - n_acc - int'(out_valid) > FDEP) occ_bad++;
      if (prev_v && !prev_r && !aborted && (!out_valid || out_data !== prev_d)) stab_bad++;
      if (busy_chk && cyc > s_cyc && n_done == 0 && n_ab == 0)
        if (busy !== ((exp_len_now != 0) && !done)) busy_bad++;
      if (out_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
        n_acc++;
        last_hs_cyc = cyc;
      end
      if (mem_en) n_rd++;
      if (done && cyc != s_cyc) begin n_done++; done_cyc = cyc; end
      if (aborted && cyc != s_cyc) n_ab++;
      prev_v = out_valid; prev_r = out_ready; prev_d = out_data;
    end
  end

`ifdef ACMAC_TX_FCS_EN
  function automatic logic [31:0] crc_ref(input byte unsigned q[$]);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (q[i])
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return ~c;
  endfunction
`endif

  // Caller is positioned just after a rising edge; start is driven in this cycle.
  task automatic run_frame(input int base, input int len, input int rm, input int lat,
                           input int dup, input int exp_n, input string tag);
    byte unsigned exp_q[$];
    int t, mism, nlast, lpos, sz;
    for (int i = 0; i < exp_n; i++) exp_q.push_back(mem_arr[(base + i) % DEPTH]);
`ifdef ACMAC_TX_FCS_EN
    if (exp_n > 0) begin
      logic [31:0] c;
      c = crc_ref(exp_q);
      for (int k = 0; k < 4; k++) exp_q.push_back(8'(c >> (8 * k)));
    end
`endif
    rmode = rm;
    clear_mon();
    base_addr = 8'(base); frame_len = 8'(len); start = 1'b1;
    s_cyc = cyc; exp_len_now = exp_n; busy_chk = 1;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
      start = (dup > 0 && cyc == s_cyc + dup);
      if (start) begin base_addr = 8'h00; frame_len = 8'd3; end
    end while (n_done == 0 && n_ab == 0 && t < 3000);
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    busy_chk = 0;
    sz = exp_q.size();
    chk({tag, " timeout"}, int'(t >= 3000), 0);
    chk({tag, " byte count"}, got_q.size(), sz);
    mism = 0;
    for (int i = 0; i < sz && i < got_q.size(); i++) if (got_q[i] != exp_q[i]) mism++;
    chk({tag, " data mismatches"}, mism, 0);
    nlast = 0; lpos = -1;
    foreach (last_q[i]) if (last_q[i]) begin nlast++; lpos = i; end
    chk({tag, " last count"}, nlast, (sz > 0) ? 1 : 0);
    if (sz > 0) chk({tag, " last position"}, lpos, sz - 1);
    chk({tag, " done pulses"}, n_done, 1);
    chk({tag, " aborted pulses"}, n_ab, 0);
    chk({tag, " reads issued"}, n_rd, exp_n);
    chk({tag, " fifo occupancy"}, occ_bad, 0);
    chk({tag, " stall stability"}, stab_bad, 0);
    chk({tag, " busy"}, busy_bad, 0);
    chk({tag, " wen/addr"}, wen_bad + addr_bad, 0);
    if (sz == 0) chk({tag, " done latency"}, done_cyc - s_cyc, 1);
    else         chk({tag, " done after last"}, done_cyc - last_hs_cyc, 1);
    if (rm == 0 && sz > 0) chk({tag, " no bubbles"}, last_hs_cyc - first_v_cyc, sz - 1);
    if (lat != 0 && sz > 0) chk({tag, " first valid latency"}, first_v_cyc - s_cyc, 3);
  endtask

  typedef struct {
    int base; int len; int rm; int lat; int dup; int exp_n;
  } vec_t;

  initial begin : main
    vec_t vecs[7];
    int s, mism, b, l;
    vecs[0] = '{base: 0,   len: 4,   rm: 0, lat: 1, dup: 0, exp_n: 4};
    vecs[1] = '{base: 206, len: 4,   rm: 0, lat: 1, dup: 0, exp_n: 4};
    vecs[2] = '{base: 10,  len: 8,   rm: 1, lat: 1, dup: 0, exp_n: 8};
    vecs[3] = '{base: 50,  len: 0,   rm: 0, lat: 0, dup: 0, exp_n: 0};
    vecs[4] = '{base: 60,  len: 5,   rm: 2, lat: 0, dup: 2, exp_n: 5};
    vecs[5] = '{base: 200, len: 250, rm: 0, lat: 1, dup: 0, exp_n: 208};
    vecs[6] = '{base: 207, len: 1,   rm: 1, lat: 1, dup: 0, exp_n: 1};

    for (int i = 0; i < DEPTH; i++) mem_arr[i] = 8'($urandom);
    mem_arr[0] = 8'hA1; mem_arr[1] = 8'hA2; mem_arr[2] = 8'hA3; mem_arr[3] = 8'hA4;
    clear_mon();

    repeat (3) @(negedge clk);
    chk("reset outputs", int'({mem_en, mem_wen, mem_addr, out_valid, out_data, out_last,
                              busy, done, aborted}), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_frame(vecs[i].base, vecs[i].len, vecs[i].rm, vecs[i].lat, vecs[i].dup,
                vecs[i].exp_n, $sformatf("vec%0d", i));

    // abort on the 3rd byte of a 10-byte frame, then an immediate restart
    rmode = 0;
    clear_mon();
    base_addr = 8'd30; frame_len = 8'd10; start = 1'b1; s = cyc; s_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort third byte shown", int'(out_valid), 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort cycle offset", cyc - s, 6);
    chk("abort out_valid dropped", int'(out_valid), 0);
    chk("abort aborted pulse", int'(aborted), 1);
    chk("abort no done", int'(done), 0);
    chk("abort busy low", int'(busy), 0);
    mism = 0;
    foreach (got_q[i]) if (got_q[i] != mem_arr[(30 + i) % DEPTH]) mism++;
    chk("abort prefix data", mism, 0);
    chk("abort at most 3 bytes", int'(got_q.size() <= 3), 1);
    run_frame(120, 6, 0, 1, 0, 6, "after abort");

`ifdef ACMAC_TX_FCS_EN
    for (int i = 0; i < 9; i++) mem_arr[100 + i] = 8'(8'h31 + i);
    run_frame(100, 9, 0, 1, 0, 9, "fcs");
    if (got_q.size() == 13) begin
      chk("fcs byte0", got_q[9],  8'h26);
      chk("fcs byte1", got_q[10], 8'h39);
      chk("fcs byte2", got_q[11], 8'hF4);
      chk("fcs byte3", got_q[12], 8'hCB);
    end
`endif

    for (int i = 0; i < DEPTH; i++) mem_arr[i] = 8'($urandom);
    for (int r = 0; r < 24; r++) begin
      b = $urandom_range(0, DEPTH - 1);
      l = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 16);
      run_frame(b, l, $urandom_range(0, 2), 0, 0, (l > DEPTH) ? DEPTH : l,
                $sformatf("rand%0d b%0d l%0d", r, b, l));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
